// File: rtl/perceptron_trainer_pkg.sv
// Shared types and default sizes for the perceptron trainer slice.
package lab1_pkg;
    localparam int unsigned WIDTH_DEF = 13;
    localparam int unsigned NUM_DEF   = 13;

    typedef logic [WIDTH_DEF-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        UPDATE,
        DONE
    } state_t;
endpackage

// File: rtl/perceptron_trainer_if.sv
// Sample/weight-port bundle between the trainer and its controller.
interface perceptron_trainer_if
    import lab1_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned NUM   = NUM_DEF
);
    localparam int unsigned AW = (NUM > 1) ? $clog2(NUM) : 1;

    logic             start;
    logic [WIDTH-1:0] inputs [NUM];
    logic             target;
    logic             y;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] weights_o [NUM];
    logic             busy;
    logic             done;
    logic [15:0]      err_cnt;

    modport master (
        output start, inputs, target, y, wr_en, wr_addr, wr_data,
        input  weights_o, busy, done, err_cnt
    );

    modport slave (
        input  start, inputs, target, y, wr_en, wr_addr, wr_data,
        output weights_o, busy, done, err_cnt
    );
endinterface

// File: rtl/perceptron_trainer_weight_alu.sv
// Shared weight adder/subtractor; PERCEPTRON_SAT_EN clamps to signed limits, otherwise wraps.
module weight_alu #(
    parameter int unsigned WIDTH = 13
) (
    input  logic [WIDTH-1:0] w,
    input  logic [WIDTH-1:0] d,
    input  logic             sub,
    output logic [WIDTH-1:0] r
);
`ifdef PERCEPTRON_SAT_EN
    logic [WIDTH:0] ext;

    always_comb begin
        ext = sub ? ({w[WIDTH-1], w} - {d[WIDTH-1], d})
                  : ({w[WIDTH-1], w} + {d[WIDTH-1], d});
        // Extra sign bit disagreeing with the result MSB means signed overflow.
        if (ext[WIDTH] != ext[WIDTH-1])
            r = ext[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        else
            r = ext[WIDTH-1:0];
    end
`else
    always_comb begin
        r = sub ? (w - d) : (w + d);
    end
`endif
endmodule

// File: rtl/perceptron_trainer.sv
// Perceptron-rule weight trainer: one weight word rewritten per cycle after a misclassified sample.
// Build option: PERCEPTRON_SAT_EN selects saturating weight arithmetic.
module perceptron_trainer
    import lab1_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned NUM   = NUM_DEF,
    parameter int unsigned SHIFT = 0
) (
    input logic                 clk,
    input logic                 rst,
    perceptron_trainer_if.slave bus
);
    localparam int unsigned    IW   = (NUM > 1) ? $clog2(NUM) : 1;
    localparam logic [IW-1:0]  LAST = IW'(NUM - 1);

    state_t           state, state_nx;
    logic [WIDTH-1:0] weights [NUM];
    logic [WIDTH-1:0] x_lat   [NUM];
    logic             tgt_lat;
    logic [IW-1:0]    idx;
    logic [15:0]      err_cnt;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] alu_out;
    logic             wr_ok;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = (bus.target == bus.y) ? DONE : UPDATE;
            UPDATE:  if (idx == LAST) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.busy      = (state != IDLE);
        bus.done      = (state == DONE);
        bus.weights_o = weights;
        bus.err_cnt   = err_cnt;
    end

    // target=1 only reaches UPDATE with y=0, so the latched target alone selects subtract.
    always_comb begin
        d     = $signed(x_lat[idx]) >>> SHIFT;
        wr_ok = bus.wr_en && (state == IDLE) && !bus.start && (32'(bus.wr_addr) < NUM);
    end

    weight_alu #(.WIDTH(WIDTH)) u_alu (
        .w   (weights[idx]),
        .d   (d),
        .sub (tgt_lat),
        .r   (alu_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM; i++) weights[i] <= '0;
            idx     <= '0;
            err_cnt <= '0;
            tgt_lat <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        x_lat   <= bus.inputs;
                        tgt_lat <= bus.target;
                        idx     <= '0;
                        if (bus.target != bus.y && err_cnt != '1)
                            err_cnt <= err_cnt + 16'd1;
                    end else if (wr_ok) begin
                        weights[bus.wr_addr] <= bus.wr_data;
                    end
                end
                UPDATE: begin
                    weights[idx] <= alu_out;
                    idx          <= idx + IW'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_perceptron_trainer.sv
// Scoreboard bench for perceptron_trainer: SHIFT=0 and SHIFT=2 instances; honours PERCEPTRON_SAT_EN.
module tb_perceptron_trainer;
    import lab1_pkg::*;

    typedef logic [12:0] wvec_t [13];
    typedef struct {
        int          lat;
        wvec_t       w;
        logic [15:0] err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    perceptron_trainer_if #(.WIDTH(13), .NUM(13)) if0 ();
    perceptron_trainer_if #(.WIDTH(13), .NUM(13)) if1 ();

    perceptron_trainer #(.WIDTH(13), .NUM(13), .SHIFT(0)) dut (
        .clk (clk), .rst (rst), .bus (if0)
    );
    perceptron_trainer #(.WIDTH(13), .NUM(13), .SHIFT(2)) dut_s (
        .clk (clk), .rst (rst), .bus (if1)
    );

    int          n_pass  = 0;
    int          n_total = 0;
    exp_t        sb [$];
    wvec_t       mw [2];
    logic [15:0] merr [2];
    int          shifts [2] = '{0, 2};

    function automatic logic [12:0] mdl_upd(logic [12:0] w, logic [12:0] x, int sh, logic sub);
        int wi, xi, r;
        wi = int'($signed(w));
        xi = int'($signed(x)) >>> sh;
        r  = sub ? wi - xi : wi + xi;
`ifdef PERCEPTRON_SAT_EN
        if (r > 4095)  r = 4095;
        if (r < -4096) r = -4096;
`endif
        return r[12:0];
    endfunction

    task automatic put_in(int which, wvec_t xv, logic tg, logic yy, logic st);
        if (which == 0) begin
            if0.inputs = xv; if0.target = tg; if0.y = yy; if0.start = st;
        end else begin
            if1.inputs = xv; if1.target = tg; if1.y = yy; if1.start = st;
        end
    endtask

    task automatic set_start(int which, logic st);
        if (which == 0) if0.start = st;
        else            if1.start = st;
    endtask

    task automatic put_wr(int which, logic en, logic [3:0] a, logic [12:0] dt);
        if (which == 0) begin
            if0.wr_en = en; if0.wr_addr = a; if0.wr_data = dt;
        end else begin
            if1.wr_en = en; if1.wr_addr = a; if1.wr_data = dt;
        end
    endtask

    task automatic get_out(int which, output logic dn, output logic bs,
                           output logic [15:0] er, output wvec_t wv);
        if (which == 0) begin
            dn = if0.done; bs = if0.busy; er = if0.err_cnt; wv = if0.weights_o;
        end else begin
            dn = if1.done; bs = if1.busy; er = if1.err_cnt; wv = if1.weights_o;
        end
    endtask

    task automatic wr(int which, logic [3:0] a, logic [12:0] dt);
        @(negedge clk);
        put_wr(which, 1'b1, a, dt);
        @(negedge clk);
        put_wr(which, 1'b0, 4'd0, 13'd0);
        if (a < 4'd13) mw[which][a] = dt;
    endtask

    task automatic cmp_weights(int which, string name);
        logic dn, bs; logic [15:0] er; wvec_t wv; int bad;
        get_out(which, dn, bs, er, wv);
        bad = -1;
        for (int k = 0; k < 13; k++)
            if (wv[k] !== mw[which][k] && bad < 0) bad = k;
        n_total++;
        if (bad >= 0)
            $display("FAIL %s: weights[%0d] got %h expected %h", name, bad, wv[bad], mw[which][bad]);
        else
            n_pass++;
    endtask

    task automatic train(int which, wvec_t xv, logic tg, logic yy,
                         int restart_at, bit wr_along, bit scramble, string name);
        exp_t e; wvec_t junk; wvec_t wv; logic dn, bs; logic [15:0] er;
        int cyc, bcnt, extra, bad; bit seen;
        e.w = mw[which];
        if (tg != yy) begin
            for (int k = 0; k < 13; k++) e.w[k] = mdl_upd(e.w[k], xv[k], shifts[which], tg);
            if (merr[which] != 16'hFFFF) merr[which] = merr[which] + 16'd1;
            e.lat = 14;
        end else begin
            e.lat = 1;
        end
        e.err = merr[which];
        mw[which] = e.w;
        sb.push_back(e);

        @(negedge clk);
        put_in(which, xv, tg, yy, 1'b1);
        if (wr_along) put_wr(which, 1'b1, 4'd0, 13'h0555);
        seen = 0; bcnt = 0; cyc = 0;
        while (cyc < 40 && !seen) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                set_start(which, 1'b0);
                put_wr(which, 1'b0, 4'd0, 13'd0);
                if (scramble) begin
                    for (int k = 0; k < 13; k++) junk[k] = ~xv[k];
                    put_in(which, junk, ~tg, ~yy, 1'b0);
                end
            end
            if (restart_at > 0 && cyc == restart_at)     set_start(which, 1'b1);
            if (restart_at > 0 && cyc == restart_at + 1) set_start(which, 1'b0);
            get_out(which, dn, bs, er, wv);
            if (bs) bcnt++;
            if (dn) seen = 1;
        end
        set_start(which, 1'b0);
        e = sb.pop_front();

        n_total++;
        if (!seen) begin
            $display("FAIL %s_done_timeout: no done within %0d cycles, expected at %0d", name, cyc, e.lat);
        end else begin
            n_pass++;
            n_total++;
            if (cyc !== e.lat) $display("FAIL %s_latency: got %0d expected %0d", name, cyc, e.lat);
            else n_pass++;
            n_total++;
            if (bcnt !== e.lat) $display("FAIL %s_busy_cycles: got %0d expected %0d", name, bcnt, e.lat);
            else n_pass++;
            n_total++;
            if (er !== e.err) $display("FAIL %s_err_cnt: got %0d expected %0d", name, er, e.err);
            else n_pass++;
            bad = -1;
            for (int k = 0; k < 13; k++) if (wv[k] !== e.w[k] && bad < 0) bad = k;
            n_total++;
            if (bad >= 0)
                $display("FAIL %s_weights: weights[%0d] got %h expected %h", name, bad, wv[bad], e.w[bad]);
            else
                n_pass++;
        end

        extra = 0;
        repeat (20) begin
            @(negedge clk);
            get_out(which, dn, bs, er, wv);
            if (dn) extra++;
        end
        n_total++;
        if (extra !== 0) $display("FAIL %s_extra_done: got %0d extra pulses expected 0", name, extra);
        else n_pass++;
    endtask

    task automatic model_reset();
        for (int j = 0; j < 2; j++) begin
            for (int k = 0; k < 13; k++) mw[j][k] = 13'd0;
            merr[j] = 16'd0;
        end
    endtask

    task automatic test_reset();
        logic dn, bs; logic [15:0] er; wvec_t wv;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        get_out(0, dn, bs, er, wv);
        n_total++;
        if (bs !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bs); else n_pass++;
        n_total++;
        if (dn !== 1'b0) $display("FAIL reset_done: got %b expected 0", dn); else n_pass++;
        n_total++;
        if (er !== 16'd0) $display("FAIL reset_err_cnt: got %0d expected 0", er); else n_pass++;
        cmp_weights(0, "reset_weights");
        cmp_weights(1, "reset_weights_shift");
    endtask

    task automatic test_mismatch_sub();
        wvec_t xv; logic dn, bs; logic [15:0] er; wvec_t wv;
        for (int k = 0; k < 13; k++) xv[k] = 13'(k + 1);
        train(0, xv, 1'b1, 1'b0, 0, 0, 1, "mismatch_sub");
        get_out(0, dn, bs, er, wv);
        n_total++;
        if (wv[0] !== 13'h1FFF) $display("FAIL sub_w0: got %h expected 1fff", wv[0]); else n_pass++;
        n_total++;
        if (wv[12] !== 13'h1FF3) $display("FAIL sub_w12: got %h expected 1ff3", wv[12]); else n_pass++;
        n_total++;
        if (er !== 16'd1) $display("FAIL sub_err_cnt: got %0d expected 1", er); else n_pass++;
    endtask

    task automatic test_match();
        wvec_t xv;
        for (int k = 0; k < 13; k++) xv[k] = 13'(3 * k + 7);
        wr(0, 4'd3, 13'd5);
        cmp_weights(0, "preload_w3");
        train(0, xv, 1'b1, 1'b1, 0, 0, 0, "match");
    endtask

    task automatic test_overflow();
        wvec_t xv; logic dn, bs; logic [15:0] er; wvec_t wv; logic [12:0] want;
        for (int k = 0; k < 13; k++) xv[k] = 13'd0;
        xv[0] = 13'd1;
        wr(0, 4'd0, 13'h0FFF);
        train(0, xv, 1'b0, 1'b1, 0, 0, 0, "overflow");
`ifdef PERCEPTRON_SAT_EN
        want = 13'h0FFF;
`else
        want = 13'h1000;
`endif
        get_out(0, dn, bs, er, wv);
        n_total++;
        if (wv[0] !== want) $display("FAIL overflow_w0: got %h expected %h", wv[0], want); else n_pass++;
    endtask

    task automatic test_shift();
        wvec_t xv; logic dn, bs; logic [15:0] er; wvec_t wv;
        for (int k = 0; k < 13; k++) xv[k] = 13'd0;
        xv[5] = 13'd12;
        train(1, xv, 1'b0, 1'b1, 0, 0, 0, "shift_pos");
        get_out(1, dn, bs, er, wv);
        n_total++;
        if (wv[5] !== 13'd3) $display("FAIL shift_pos_w5: got %h expected 0003", wv[5]); else n_pass++;
        wr(1, 4'd5, 13'd0);
        xv[5] = 13'h1FF8;
        train(1, xv, 1'b0, 1'b1, 0, 0, 0, "shift_neg");
        get_out(1, dn, bs, er, wv);
        n_total++;
        if (wv[5] !== 13'h1FFE) $display("FAIL shift_neg_w5: got %h expected 1ffe", wv[5]); else n_pass++;
    endtask

    task automatic test_bad_addr();
        wr(0, 4'd13, 13'h0AAA);
        cmp_weights(0, "bad_addr_13");
        wr(0, 4'd15, 13'h0BBB);
        cmp_weights(0, "bad_addr_15");
    endtask

    task automatic test_wr_with_start();
        wvec_t xv;
        for (int k = 0; k < 13; k++) xv[k] = 13'(k * 5 + 2);
        train(0, xv, 1'b0, 1'b1, 0, 1, 0, "wr_with_start");
    endtask

    task automatic test_back_to_back();
        wvec_t xv;
        for (int k = 0; k < 13; k++) xv[k] = 13'(100 - k);
        train(0, xv, 1'b1, 1'b0, 3, 0, 0, "start_while_busy");
        for (int k = 0; k < 13; k++) xv[k] = 13'(k);
        train(0, xv, 1'b0, 1'b0, 0, 0, 0, "match_after_busy");
    endtask

    task automatic test_reset_mid();
        wvec_t xv; logic dn, bs; logic [15:0] er; wvec_t wv; int extra;
        for (int k = 0; k < 13; k++) xv[k] = 13'(k + 9);
        @(negedge clk);
        put_in(0, xv, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        set_start(0, 1'b0);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        get_out(0, dn, bs, er, wv);
        n_total++;
        if (bs !== 1'b0) $display("FAIL reset_mid_busy: got %b expected 0", bs); else n_pass++;
        n_total++;
        if (dn !== 1'b0) $display("FAIL reset_mid_done: got %b expected 0", dn); else n_pass++;
        n_total++;
        if (er !== 16'd0) $display("FAIL reset_mid_err_cnt: got %0d expected 0", er); else n_pass++;
        cmp_weights(0, "reset_mid_weights");
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            get_out(0, dn, bs, er, wv);
            if (dn) extra++;
        end
        n_total++;
        if (extra !== 0) $display("FAIL reset_mid_no_done: got %0d pulses expected 0", extra); else n_pass++;
    endtask

    initial begin
        wvec_t zero;
        for (int k = 0; k < 13; k++) zero[k] = 13'd0;
        put_in(0, zero, 1'b0, 1'b0, 1'b0);
        put_in(1, zero, 1'b0, 1'b0, 1'b0);
        put_wr(0, 1'b0, 4'd0, 13'd0);
        put_wr(1, 1'b0, 4'd0, 13'd0);
        model_reset();

        test_reset();
        test_mismatch_sub();
        test_match();
        test_overflow();
        test_shift();
        test_bad_addr();
        test_wr_with_start();
        test_back_to_back();
        test_reset_mid();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/perceptron_trainer.md
Name: perceptron_trainer

Overview:
- Backward (learning) side of the single-layer neuron datapath: holds the NUM weight words that feed the neuron and updates them with the perceptron rule.
- Neuron computes class = MSB of sum(x*w); this block takes the inputs, the neuron's class output and the target class, then rewrites weights serially, one word per cycle.
- Sits beside the neuron; its weights_o array drives the neuron's weights input directly.

Parameters:
- WIDTH, 13, bit width of every input and weight word (two's complement).
- NUM, 13, number of inputs/weights.
- SHIFT, 0, learning rate as an arithmetic right shift applied to x[k] before update (0..WIDTH-1).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to train on the current sample.
- inputs  in  [WIDTH-1:0] x [0:NUM-1]  sample inputs.
- target  in  1  desired class bit (1 = negative sum).
- y  in  1  neuron class bit (MSB of neuron out) for the same sample.
- wr_en  in  1  direct weight write strobe.
- wr_addr  in  $clog2(NUM)  weight index for direct write.
- wr_data  in  WIDTH  weight value for direct write.
- weights_o  out  [WIDTH-1:0] x [0:NUM-1]  current weights, to neuron.
- busy  out  1  high while not IDLE.
- done  out  1  one-cycle pulse, sample finished.
- err_cnt  out  16  count of samples with target != y.

Behaviour:
- Reset (rst=1 at clk edge): all weights_o = 0, busy = 0, done = 0, err_cnt = 0, state IDLE, index = 0. Applies mid-update: the update is abandoned, no done pulse.
- FSM states: IDLE, UPDATE, DONE.
- IDLE, start=1: latch inputs, target, y.
  - target == y: go to DONE.
  - otherwise: go to UPDATE with index = 0, and err_cnt += 1 (saturates at 16'hFFFF).
- UPDATE: each cycle updates w[index] using d = latched x[index] >>> SHIFT.
  - target=0, y=1 (sum too negative): w[index] += d.
  - target=1, y=0: w[index] -= d.
  - Index increments; after index NUM-1, go to DONE.
- DONE: done=1 for exactly this cycle, then IDLE.
- Latency from start sampled: match → done high in cycle +1; mismatch → done high in cycle +NUM+1. busy is high from cycle +1 until the DONE cycle inclusive.
- start while busy: ignored, not queued. Inputs may change after the start cycle.
- wr_en honoured only in IDLE with start=0: w[wr_addr] <= wr_data. wr_addr >= NUM: ignored. wr_en while busy or together with start: dropped.
- Arithmetic: modulo 2^WIDTH wrap, identical to neuron adder semantics.
- weights_o are registers, updated at the clock edge.

Optional Feature:
- Macro: PERCEPTRON_SAT_EN.
- Defined: weight add/sub saturates to signed limits [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- Undefined: plain wrap-around.
- Ports and timing are identical in both builds.

Decomposition:
- Package lab1_pkg:
  - default WIDTH/NUM constants (13/13).
  - typedef word_t (logic [WIDTH-1:0]).
  - enum state_t {IDLE, UPDATE, DONE}.
- Sub-module weight_alu: combinational w ± d with the PERCEPTRON_SAT_EN saturation option; instantiated once and shared across indices.

Test Plan:
- Reset, all weights 0; x[k]=k+1; target=1, y=0; pulse start → done at cycle +14, w[0]=13'h1FFF, w[12]=13'h1FF3 (-13), err_cnt=1.
- Weights preloaded via wr_en (w[3]=5); target=y=1; start → done at cycle +1, no weights change, err_cnt unchanged, busy high for 1 cycle.
- Direct write w[0]=13'h0FFF, x[0]=1, target=0, y=1:
  - start without macro → w[0]=13'h1000.
  - start with PERCEPTRON_SAT_EN → w[0]=13'h0FFF.
- SHIFT=2, x[5]=13'd12, target=0, y=1, w zero → w[5]=3. Also x[5]=-8 → w[5]=-2 (13'h1FFE).
- rst asserted at UPDATE index 6 → next cycle all weights 0, busy=0, no done pulse. Second start pulse while busy → ignored, only one done.
- wr_en with wr_addr=13 → no weight changes. wr_en coincident with start → write dropped, update proceeds.
